mux2_1_arb: RTL and testbench

Two-input round-robin arbiter with a registered output stage, sitting directly upstream of `mux2_1`: it decides which of two valid/ready sources is forwarded each cycle, drives the mux `selector`, and registers the selected word for the next stage. It turns the purely combinational 2:1 select into a fair, back-pressured, one-entry pipeline stage. Throughput is one word per cycle, latency is one cycle.

---
 rtl/mux2_1_arb.sv | 82 ++++++++
 tb/tb_mux2_1_arb.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mux2_1_arb.sv
// Two-source round-robin arbiter feeding a one-entry registered output stage.
// Drives the downstream 2:1 mux selector and holds the granted word until consumed.
module mux2_1_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_0,
    input  logic             v_0,
    output logic             r_0,
    input  logic [WIDTH-1:0] d_1,
    input  logic             v_1,
    output logic             r_1,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             selector
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;

    logic can_accept;
    logic gnt_vld;
    logic gnt;
    logic xfer;

    // Grant is independent of can_accept so readies never feed back into valids.
    always_comb begin
        gnt_vld    = v_0 | v_1;
        gnt        = (v_0 & v_1) ? ~last_q : v_1;
        can_accept = (state_q == EMPTY) | out_ready;
        xfer       = can_accept & gnt_vld;
        r_0        = xfer & ~gnt;
        r_1        = xfer & gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // A transfer refills the stage even while it drains, so no bubble appears.
    always_comb begin
        state_d = state_q;
        if (xfer)
            state_d = FULL;
        else if (out_ready)
            state_d = EMPTY;
    end

    always_comb begin
        out_d  = out_q;
        sel_d  = sel_q;
        last_d = last_q;
        if (xfer) begin
            out_d  = gnt ? d_1 : d_0;
            sel_d  = gnt;
            last_d = gnt;
        end
    end

    always_comb begin
        out_valid = (state_q == FULL);
        out       = out_q;
        selector  = sel_q;
    end

endmodule

// File: tb/tb_mux2_1_arb.sv
// Directed bench for mux2_1_arb: reset, single source, contention,
// back-pressure and asynchronous reset mid-operation.
module tb_mux2_1_arb;

    logic       clk;
    logic       rst_n;
    logic [7:0] d_0, d_1;
    logic       v_0, v_1;
    logic       r_0, r_1;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       selector;

    int total = 0;
    int bad   = 0;

    mux2_1_arb #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_0       (d_0),
        .v_0       (v_0),
        .r_0       (r_0),
        .d_1       (d_1),
        .v_1       (v_1),
        .r_1       (r_1),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .selector  (selector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] o, input logic s, input logic v);
        chk({tag, ".out"}, {24'd0, out}, {24'd0, o});
        chk({tag, ".sel"}, {31'd0, selector}, {31'd0, s});
        chk({tag, ".vld"}, {31'd0, out_valid}, {31'd0, v});
    endtask

    task automatic chk_rdy(input string tag, input logic e0, input logic e1);
        chk({tag, ".r0"}, {31'd0, r_0}, {31'd0, e0});
        chk({tag, ".r1"}, {31'd0, r_1}, {31'd0, e1});
    endtask

    initial begin
        rst_n = 1'b0; v_0 = 1'b0; v_1 = 1'b0; d_0 = 8'h00; d_1 = 8'h00; out_ready = 1'b0;
        #1;
        chk_out("rst", 8'h00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_rdy("idle", 1'b0, 1'b0);
        tick();
        chk_out("idle", 8'h00, 1'b0, 1'b0);

        // single source
        v_0 = 1'b1; d_0 = 8'hA5; out_ready = 1'b1;
        #1;
        chk_rdy("single", 1'b1, 1'b0);
        tick();
        v_0 = 1'b0;
        chk_out("single", 8'hA5, 1'b0, 1'b1);
        tick();
        chk_out("drain", 8'hA5, 1'b0, 1'b0);

        // fresh reset so source 0 wins the first contended cycle
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        v_0 = 1'b1; v_1 = 1'b1; d_0 = 8'h11; d_1 = 8'h22; out_ready = 1'b1;
        #1;
        chk_rdy("cont0", 1'b1, 1'b0);
        tick(); chk_out("cont1", 8'h11, 1'b0, 1'b1);
        tick(); chk_out("cont2", 8'h22, 1'b1, 1'b1);
        tick(); chk_out("cont3", 8'h11, 1'b0, 1'b1);
        tick(); chk_out("cont4", 8'h22, 1'b1, 1'b1);
        tick(); chk_out("cont5", 8'h11, 1'b0, 1'b1);

        // back-pressure while holding 11
        out_ready = 1'b0;
        #1;
        chk_rdy("bp", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp_hold", 8'h11, 1'b0, 1'b1);
            chk_rdy("bp_hold", 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk_rdy("bp_rel", 1'b0, 1'b1);
        tick();
        chk_out("bp_rel", 8'h22, 1'b1, 1'b1);

        // asynchronous reset between edges while FULL with 22
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_rdy("post_rst", 1'b1, 1'b0);
        tick();
        chk_out("post_rst", 8'h11, 1'b0, 1'b1);

        // lone source 1 is granted even though it was... last priority moved to 0
        v_0 = 1'b0;
        #1;
        chk_rdy("only1", 1'b0, 1'b1);
        tick();
        chk_out("only1", 8'h22, 1'b1, 1'b1);
        v_1 = 1'b0; out_ready = 1'b0;
        tick();
        chk_out("hold_idle", 8'h22, 1'b1, 1'b1);
        out_ready = 1'b1;
        tick();
        chk_out("drain2", 8'h22, 1'b1, 1'b0);

        // after source 1 last, contention goes to source 0
        v_0 = 1'b1; v_1 = 1'b1;
        #1;
        chk_rdy("rr_after1", 1'b1, 1'b0);
        tick();
        chk_out("rr_after1", 8'h11, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
